oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameters SHALL be, one per line:
  OAM_BASE, 16'hFE00, destination base address.
  XFER_LEN, 160, bytes per transfer.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state changes on its rising edge
  reset_n  in  1  synchronous, active-low reset
  reg_wr  in  1  one-cycle strobe; CPU write to DMA register (decoded externally)
  reg_wdata  in  8  source page (high byte of source address)
  reg_rdata  out  8  last page value written
  dma_active  out  1  high from accepted start until the cycle after the last write
  bus_req  out  1  request for bus mastership
  bus_gnt  in  1  arbiter grant
  m_addr  out  16  master address
  m_rd  out  1  master read strobe, one cycle
  m_rdata  in  8  read data, valid in the cycle after m_rd
  m_wr  out  1  master write strobe, one cycle
  m_wdata  out  8  master write data
  done  out  1  one-cycle pulse after the final byte is written

Function
REQ-003 FSM states SHALL be IDLE, REQ, RD, LAT, WR.
REQ-004 In IDLE, reg_wr SHALL latch reg_wdata into page and reg_rdata, clear index to 0, and enter REQ on the next edge.
REQ-005 In REQ, bus_req SHALL be 1; the FSM SHALL enter RD on the first cycle bus_gnt=1.
REQ-006 In RD, the block SHALL drive m_rd=1 and m_addr={page,index[7:0]}.
REQ-007 In LAT, the block SHALL capture m_rdata into a holding register at the end of the cycle.
REQ-008 In WR, the block SHALL drive m_wr=1, m_addr=OAM_BASE+index and m_wdata=holding register; index SHALL then increment.
REQ-009 Each byte SHALL take exactly 3 cycles, so a full uncontested transfer is 3*XFER_LEN cycles from the first RD.
REQ-010 After WR, the FSM SHALL go to RD if index<XFER_LEN and bus_gnt=1.
REQ-011 After WR, the FSM SHALL go to REQ if index<XFER_LEN and bus_gnt=0; a byte already in RD or LAT SHALL always complete.
REQ-012 After WR with index==XFER_LEN, the FSM SHALL enter IDLE and pulse done for 1 cycle; dma_active SHALL drop in the same cycle.
REQ-013 bus_req SHALL stay high in all states except IDLE.
REQ-014 Outside their states, m_rd and m_wr SHALL be 0.
REQ-015 Outside active states, m_addr and m_wdata SHALL hold their last values.
REQ-016 reg_wr while not IDLE SHALL restart the transfer: new page latched, index=0, state=REQ; any RD/LAT in flight SHALL be abandoned without a write.
REQ-017 reg_wr coincident with the final WR SHALL complete that write, suppress done, and restart.
REQ-018 index SHALL be 8 bits; index never exceeds XFER_LEN, so there is no wrap.

Reset
REQ-019 With reset_n=0 at a clock edge, the block SHALL set state=IDLE, index=0, page=0, reg_rdata=0, holding register=0 and all outputs to 0 (m_addr=16'h0000).
REQ-020 Reset mid-transfer SHALL abort the transfer; no m_wr SHALL follow, and done SHALL NOT pulse.

Configuration
REQ-021 Macro DMA_ECHO_REMAP_EN defined: a page in 8'hE0..8'hFF SHALL be remapped to page-8'h20 for m_addr only; reg_rdata SHALL keep the written value.
REQ-022 Macro DMA_ECHO_REMAP_EN undefined: the page SHALL be used verbatim.

Structure
REQ-023 DMA_REG_ADDR (16'hFF46), OAM_DMA_LEN (160) and enum dma_state_t SHALL be added to package video_types; OAM_BASE SHALL default from the existing OAM_LOC constant.
REQ-024 The block SHALL be a single FSM with its counters; no sub-module is warranted.

Verification
REQ-025 Bench SHALL cover the following directed scenarios:
  Basic: reg_wr 8'hC1, bus_gnt=1 -> 160 writes FE00..FE9F with data from C100..C19F; done 480 cycles after the first RD.
  Grant stall: drop bus_gnt for 10 cycles after byte 5 -> byte 5 written; m_rd stops and resumes at C106; total cycles +10; data intact.
  Restart: reg_wr 8'h80 during byte 50 -> no write for the in-flight byte; next write to FE00 sourced from 8000.
  Reset: reset_n=0 at byte 20 -> outputs 0 next cycle; no further m_wr; done never pulses.
  Echo: reg_wr 8'hE2 -> with DMA_ECHO_REMAP_EN, reads from C200..C29F; without it, reads from E200..E29F; reg_rdata reads 8'hE2 in both builds.

Source files
------------

// File: rtl/video_types_pkg.sv
// Shared video-subsystem constants and types; the OAM DMA engine pulls its
// register address, transfer length, OAM location and FSM state type from here.
package video_types;

  localparam logic [15:0] OAM_LOC      = 16'hFE00;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_DMA_LEN  = 160;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    LAT,
    WR
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies XFER_LEN bytes from {page,8'h00} to OAM_BASE, 3 cycles per byte.
// Optional macro DMA_ECHO_REMAP_EN remaps source pages E0..FF down by 8'h20 (address only).
module oam_dma
  import video_types::*;
#(
  parameter logic [15:0] OAM_BASE = OAM_LOC,
  parameter int          XFER_LEN = OAM_DMA_LEN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        dma_active,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_addr,
  output logic        m_rd,
  input  logic [7:0]  m_rdata,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  output logic        done
);

  localparam logic [7:0] LEN8 = 8'(XFER_LEN);

  dma_state_t  state, state_next;
  logic [7:0]  page, page_next;
  logic [7:0]  index, index_next;
  logic [7:0]  index_inc;
  logic [7:0]  hold, hold_next;
  logic        done_next;
  logic [15:0] m_addr_next;
  logic [7:0]  m_wdata_next;

  function automatic logic [7:0] source_page(input logic [7:0] p);
`ifdef DMA_ECHO_REMAP_EN
    if (p >= 8'hE0) begin
      return p - 8'h20;
    end
`endif
    return p;
  endfunction

  assign index_inc = index + 8'd1;
  assign reg_rdata = page;

  // A register write always wins: it restarts from byte 0 whatever state we are in,
  // dropping any byte still in RD/LAT; a write already in WR has been issued this cycle.
  always_comb begin
    state_next = state;
    page_next  = page;
    index_next = index;
    hold_next  = hold;
    done_next  = 1'b0;
    case (state)
      IDLE: state_next = IDLE;
      REQ:  if (bus_gnt) state_next = RD;
      RD:   state_next = LAT;
      LAT: begin
        hold_next  = m_rdata;
        state_next = WR;
      end
      WR: begin
        index_next = index_inc;
        if (index_inc == LEN8) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (bus_gnt) begin
          state_next = RD;
        end else begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reg_wr) begin
      page_next  = reg_wdata;
      index_next = 8'd0;
      state_next = REQ;
      done_next  = 1'b0;
    end
  end

  // Bus outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    m_addr_next  = m_addr;
    m_wdata_next = m_wdata;
    case (state_next)
      RD: m_addr_next = {source_page(page_next), index_next};
      WR: begin
        m_addr_next  = OAM_BASE + {8'h00, index_next};
        m_wdata_next = hold_next;
      end
      default: m_addr_next = m_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      page       <= 8'h00;
      index      <= 8'd0;
      hold       <= 8'h00;
      m_addr     <= 16'h0000;
      m_wdata    <= 8'h00;
      m_rd       <= 1'b0;
      m_wr       <= 1'b0;
      bus_req    <= 1'b0;
      dma_active <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      page       <= page_next;
      index      <= index_next;
      hold       <= hold_next;
      m_addr     <= m_addr_next;
      m_wdata    <= m_wdata_next;
      m_rd       <= (state_next == RD);
      m_wr       <= (state_next == WR);
      bus_req    <= (state_next != IDLE);
      dma_active <= (state_next != IDLE);
      done       <= done_next;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected reads/writes are queued per accepted
// register write and matched by an independent bus monitor.
module tb_oam_dma;
  import video_types::*;

  localparam int XFER = 160;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        dma_active;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] m_addr;
  logic        m_rd;
  logic [7:0]  m_rdata;
  logic        m_wr;
  logic [7:0]  m_wdata;
  logic        done;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .dma_active (dma_active),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .m_addr     (m_addr),
    .m_rd       (m_rd),
    .m_rdata    (m_rdata),
    .m_wr       (m_wr),
    .m_wdata    (m_wdata),
    .done       (done)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] expRd[$];
  wr_t         expWr[$];
  wr_t         wItem;
  int          nChecks = 0;
  int          nErrors = 0;
  int          cycle = 0;
  logic        monEn = 1'b0;
  logic        doneExpected = 1'b0;
  logic [7:0]  rdataExp = 8'h00;
  int          doneCount = 0;
  int          firstRdCycle = 0;
  int          doneCycle = 0;
  int          rdIdx = 0;
  logic        rdPending = 1'b0;
  logic [15:0] rdAddr = 16'h0000;
  logic        gntRandom = 1'b0;

  function automatic logic [7:0] effPage(input logic [7:0] p);
`ifdef DMA_ECHO_REMAP_EN
    if (p >= 8'hE0) return p - 8'h20;
`endif
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Issued at posedge+1; the model switches to the new transfer at the accepting edge.
  task automatic applyStimulus(input logic [7:0] page);
    reg_wdata = page;
    reg_wr    = 1'b1;
    @(posedge clk);
    expRd.delete();
    expWr.delete();
    for (int i = 0; i < XFER; i++) begin
      expRd.push_back({effPage(page), 8'(i)});
      expWr.push_back(wr_t'{addr: 16'hFE00 + 16'(i), data: mem[{effPage(page), 8'(i)}]});
    end
    rdIdx        = 0;
    doneExpected = 1'b1;
    rdataExp     = page;
    #1 reg_wr = 1'b0;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    @(posedge clk);
    expRd.delete();
    expWr.delete();
    doneExpected = 1'b0;
    rdataExp     = 8'h00;
    #1;
    checkOutput("rst_reg_rdata", 32'(reg_rdata), 32'h0);
    checkOutput("rst_dma_active", 32'(dma_active), 32'h0);
    checkOutput("rst_bus_req", 32'(bus_req), 32'h0);
    checkOutput("rst_m_addr", 32'(m_addr), 32'h0);
    checkOutput("rst_m_rd", 32'(m_rd), 32'h0);
    checkOutput("rst_m_wr", 32'(m_wr), 32'h0);
    checkOutput("rst_m_wdata", 32'(m_wdata), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic waitDone(input int limit);
    int start = doneCount;
    int n = 0;
    while (doneCount == start && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("done_seen", 32'(doneCount != start), 32'h1);
  endtask

  task automatic waitEvent(input logic isWr, input logic [15:0] a, input int limit);
    logic found = 1'b0;
    for (int n = 0; n < limit && !found; n++) begin
      @(posedge clk);
      #1;
      if ((isWr ? m_wr : m_rd) === 1'b1 && m_addr === a) found = 1'b1;
    end
    checkOutput("event_seen", 32'(found), 32'h1);
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Source memory: valid data only in the cycle after m_rd, garbage otherwise.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdPending) begin
      m_rdata   = mem[rdAddr];
      rdPending = 1'b0;
    end else begin
      m_rdata = 8'($urandom);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (gntRandom) bus_gnt = ($urandom_range(0, 9) < 7);
  end

  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("reg_rdata", 32'(reg_rdata), 32'(rdataExp));
      if (m_rd === 1'b1) begin
        rdPending = 1'b1;
        rdAddr    = m_addr;
        checkOutput("rd_expected", 32'(expRd.size() > 0), 32'h1);
        if (expRd.size() > 0) begin
          if (rdIdx == 0) firstRdCycle = cycle;
          rdIdx++;
          checkOutput("rd_addr", 32'(m_addr), 32'(expRd.pop_front()));
        end
      end
      if (m_wr === 1'b1) begin
        checkOutput("wr_expected", 32'(expWr.size() > 0), 32'h1);
        if (expWr.size() > 0) begin
          wItem = expWr.pop_front();
          checkOutput("wr_addr", 32'(m_addr), 32'(wItem.addr));
          checkOutput("wr_data", 32'(m_wdata), 32'(wItem.data));
        end
      end
      if (done === 1'b1) begin
        checkOutput("done_expected", 32'(doneExpected), 32'h1);
        checkOutput("done_after_last_wr", 32'(expWr.size()), 32'h0);
        checkOutput("active_at_done", 32'(dma_active), 32'h0);
        doneExpected = 1'b0;
        doneCycle    = cycle;
        doneCount++;
      end
    end
  end

  initial begin
    int savedDone;
    logic [7:0] pg;
    reset_n   = 1'b0;
    reg_wr    = 1'b0;
    reg_wdata = 8'h00;
    bus_gnt   = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    @(posedge clk);
    @(posedge clk);
    #1;
    applyReset();
    monEn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] basic transfer from page C1");
    applyStimulus(8'hC1);
    waitDone(1000);
    checkOutput("basic_cycles", 32'(doneCycle - firstRdCycle), 32'd480);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("addr_hold_idle", 32'(m_addr), 32'hFE9F);
    checkOutput("bus_req_idle", 32'(bus_req), 32'h0);

    $display("[TB] grant stall after byte 5");
    applyStimulus(8'h5A);
    waitEvent(1'b1, 16'hFE05, 100);
    bus_gnt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (k == 4) begin
        #1;
        checkOutput("stall_bus_req", 32'(bus_req), 32'h1);
        checkOutput("stall_no_rd", 32'(m_rd), 32'h0);
      end
    end
    #1 bus_gnt = 1'b1;
    waitDone(1000);
    checkOutput("stall_cycles", 32'(doneCycle - firstRdCycle), 32'd490);

    $display("[TB] restart during byte 50");
    applyStimulus(8'hC3);
    waitEvent(1'b0, 16'hC332, 400);
    applyStimulus(8'h80);
    waitDone(1000);

    $display("[TB] restart coincident with final write");
    applyStimulus(8'h44);
    waitEvent(1'b1, 16'hFE9F, 1000);
    applyStimulus(8'h55);
    waitDone(1000);
    checkOutput("restart_cycles", 32'(doneCycle - firstRdCycle), 32'd480);

    $display("[TB] reset during byte 20");
    applyStimulus(8'h66);
    waitEvent(1'b1, 16'hFE14, 200);
    savedDone = doneCount;
    applyReset();
    repeat (600) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", 32'(doneCount), 32'(savedDone));

    $display("[TB] echo page E2");
    applyStimulus(8'hE2);
    waitDone(1000);
    checkOutput("echo_rdata", 32'(reg_rdata), 32'hE2);

    $display("[TB] randomized transfers");
    gntRandom = 1'b1;
    for (int t = 0; t < 10; t++) begin
      pg = 8'($urandom);
      applyStimulus(pg);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(5, 400)) @(posedge clk);
        #1;
        pg = 8'($urandom);
        applyStimulus(pg);
      end
      waitDone(5000);
    end
    gntRandom = 1'b0;
    bus_gnt   = 1'b1;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
